// File: rtl/down_counter_pkg.sv
// Shared types and default sizing for the down-counter controller and its datapath.
package down_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/down_counter_core.sv
// Down-counter datapath: clear beats load beats decrement, and the value saturates at zero.
module down_counter_core
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec_en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Counter register with clr > load > dec priority and saturation at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= ZERO_C;
        end else if (clr) begin
            count_r <= ZERO_C;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec_en && (count_r != ZERO_C)) begin
            count_r <= count_r - ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/down_counter_ctrl.sv
// Sequencing controller for a down counter: start/pause/resume/abort, tc pulse, auto-reload.
// Define DOWN_COUNTER_CTRL_PRESCALE_EN to gate decrements with a PRESCALE-cycle prescaler.
module down_counter_ctrl
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             resume,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    if (PRESCALE < 2) begin : g_prescale_check
        $error("PRESCALE must be at least 2");
    end

    state_e           state_r;
    logic             tc_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] reload_val_r;
    logic             reload_mode_r;

    logic [WIDTH-1:0] count_s;
    logic             core_clr_s;
    logic             core_load_s;
    logic             core_dec_s;
    logic [WIDTH-1:0] core_val_s;
    logic             presc_wrap_s;
    logic             step_s;
    logic             count_zero_s;
    logic             count_one_s;
    logic             start_zero_s;

`ifdef DOWN_COUNTER_CTRL_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_r;

    assign presc_wrap_s = (presc_r == PW'(PRESCALE - 1));

    // Prescaler phase: restarts on start/abort, runs only while actively counting, holds in PAUSE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= {PW{1'b0}};
        end else if (abort || start) begin
            presc_r <= {PW{1'b0}};
        end else if ((state_r == ST_COUNT) && !pause) begin
            presc_r <= presc_wrap_s ? {PW{1'b0}} : (presc_r + {{(PW-1){1'b0}}, 1'b1});
        end else begin
            presc_r <= presc_r;
        end
    end
`else
    assign presc_wrap_s = 1'b1;
`endif

    assign count_zero_s = (count_s == ZERO_C);
    assign count_one_s  = (count_s == ONE_C);
    assign start_zero_s = (load_val == ZERO_C);
    // An enabled counting edge; the count=0 hold phase is gated by the prescaler too.
    assign step_s       = (state_r == ST_COUNT) && !pause && presc_wrap_s;

    // Datapath commands derived from the same priority order the FSM uses.
    always_comb begin
        core_clr_s  = 1'b0;
        core_load_s = 1'b0;
        core_dec_s  = 1'b0;
        core_val_s  = load_val;
        if (abort) begin
            core_clr_s = 1'b1;
        end else if (start) begin
            if (start_zero_s) begin
                core_clr_s = 1'b1;
            end else begin
                core_load_s = 1'b1;
            end
        end else if (step_s) begin
            if (count_zero_s) begin
                core_load_s = reload_mode_r;
                core_val_s  = reload_val_r;
            end else begin
                core_dec_s = 1'b1;
            end
        end else begin
            core_dec_s = 1'b0;
        end
    end

    // Controller FSM with registered status outputs and the start-time latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            tc_r          <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            reload_val_r  <= ZERO_C;
            reload_mode_r <= 1'b0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            tc_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            reload_val_r  <= load_val;
            reload_mode_r <= auto_reload;
            if (start_zero_s) begin
                state_r <= ST_DONE;
                tc_r    <= 1'b1;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
            end else begin
                state_r <= ST_COUNT;
                tc_r    <= 1'b0;
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_COUNT: begin
                    if (pause) begin
                        state_r <= ST_PAUSE;
                        tc_r    <= 1'b0;
                    end else if (step_s) begin
                        if (count_zero_s) begin
                            tc_r <= 1'b0;
                            if (reload_mode_r) begin
                                state_r <= ST_COUNT;
                            end else begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            // tc lands on the same edge the count reaches zero.
                            tc_r <= count_one_s;
                        end
                    end else begin
                        tc_r <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    tc_r <= 1'b0;
                    if (resume && !pause) begin
                        state_r <= ST_COUNT;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_IDLE: begin
                    tc_r <= 1'b0;
                end
                ST_DONE: begin
                    tc_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    tc_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    down_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load_s),
        .load_val (core_val_s),
        .dec_en   (core_dec_s),
        .clr      (core_clr_s),
        .count    (count_s)
    );

    assign count = count_s;
    assign tc    = tc_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed scoreboard bench for down_counter_ctrl; expected outputs come from a behavioural model.
module tb_down_counter_ctrl;

    localparam int W = 4;
    localparam int P = 4;
`ifdef DOWN_COUNTER_CTRL_PRESCALE_EN
    localparam int SCALE = P;
`else
    localparam int SCALE = 1;
`endif

    localparam int S_IDLE  = 0;
    localparam int S_COUNT = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] load_val;
    logic         auto_reload;
    logic         pause;
    logic         resume;
    logic         abort;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];

    int           checks;
    int           errors;
    int           m_st;
    int           m_ps;
    logic [W-1:0] m_cnt;
    logic [W-1:0] m_rel;
    logic         m_mode;
    logic         m_tc;
    logic         m_busy;
    logic         m_done;

    down_counter_ctrl #(
        .WIDTH(W),
        .PRESCALE(P)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .pause       (pause),
        .resume      (resume),
        .abort       (abort),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = S_IDLE;
        m_ps   = 0;
        m_cnt  = '0;
        m_rel  = '0;
        m_mode = 1'b0;
        m_tc   = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        logic en;
        if (abort) begin
            m_st = S_IDLE; m_cnt = '0; m_tc = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ps = 0;
        end else if (start) begin
            m_rel  = load_val;
            m_mode = auto_reload;
            m_ps   = 0;
            if (load_val == 0) begin
                m_st = S_DONE; m_cnt = '0; m_tc = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_st = S_COUNT; m_cnt = load_val; m_tc = 1'b0; m_busy = 1'b1; m_done = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
            if (m_st == S_COUNT) begin
                if (pause) begin
                    m_st = S_PAUSE;
                end else begin
`ifdef DOWN_COUNTER_CTRL_PRESCALE_EN
                    en   = (m_ps == P - 1);
                    m_ps = en ? 0 : m_ps + 1;
`else
                    en = 1'b1;
`endif
                    if (en) begin
                        if (m_cnt == 0) begin
                            if (m_mode) begin
                                m_cnt = m_rel;
                            end else begin
                                m_st = S_DONE; m_busy = 1'b0; m_done = 1'b1;
                            end
                        end else begin
                            m_cnt = m_cnt - 1'b1;
                            m_tc  = (m_cnt == 0);
                        end
                    end
                end
            end else if (m_st == S_PAUSE) begin
                if (resume && !pause) m_st = S_COUNT;
            end
        end
        exp_q.push_back({m_cnt, m_tc, m_busy, m_done});
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("count", count, e.cnt);
        chk("tc",    tc,    e.tc);
        chk("busy",  busy,  e.busy);
        chk("done",  done,  e.done);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; start = 1'b0; load_val = '0; auto_reload = 1'b0;
        pause = 1'b0; resume = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_tc",    tc,    0);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        reset = 1'b1;

        // Reset mid-count, then restart from 9
        load_val = 4'd9; start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_busy",  busy,  0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_count", count, 0);
        reset = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_count", count, 9);
        repeat (2) tick();

        // One-shot from 5
        load_val = 4'd5; auto_reload = 1'b0; start = 1'b1; tick(); start = 1'b0;
        repeat (8 * SCALE) tick();

        // Auto-reload from 2
        load_val = 4'd2; auto_reload = 1'b1; start = 1'b1; tick(); start = 1'b0; auto_reload = 1'b0;
        repeat (7 * SCALE) tick();

        // Pause at 4 (mid-prescale when enabled), then resume
        load_val = 4'd6; start = 1'b1; tick(); start = 1'b0;
        repeat (2 * SCALE + SCALE / 2) tick();
        pause = 1'b1;
        repeat (5) tick();
        chk("pause_hold", count, 4);
        resume = 1'b1; tick();
        pause = 1'b0; tick();
        chk("resume_count", count, 4);
        resume = 1'b0;
        repeat (7 * SCALE) tick();

        // abort + start together wins abort
        load_val = 4'd8; start = 1'b1; tick();
        abort = 1'b1; tick();
        chk("abort_start_count", count, 0);
        chk("abort_start_busy",  busy,  0);
        abort = 1'b0; start = 1'b0;

        // start with zero goes straight to DONE with one tc pulse
        load_val = 4'd0; start = 1'b1; tick(); start = 1'b0;
        chk("zero_tc",   tc,   1);
        chk("zero_done", done, 1);
        pause = 1'b1; resume = 1'b1; tick();
        chk("zero_tc_clear", tc, 0);
        pause = 1'b0; resume = 1'b0;

        // restart during COUNT at 3 with 7
        load_val = 4'd5; start = 1'b1; tick(); start = 1'b0;
        repeat (2 * SCALE) tick();
        load_val = 4'd7; start = 1'b1; tick(); start = 1'b0;
        chk("restart_7", count, 7);
        pause = 1'b1; tick(); pause = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        resume = 1'b1; tick(); resume = 1'b0;
        pause = 1'b1; tick(); pause = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
- Sequencing controller for a WIDTH-bit down counter. Software or upstream logic programs a start value and then starts, pauses, resumes or aborts the count.
- Generates a terminal-count pulse, busy/done status and optional auto-reload for periodic timing.
- Sits between control logic and the counter datapath. The datapath is instantiated inside this block as a sub-module.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESCALE, 4, clock cycles per decrement; used only when the optional feature is compiled in; must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  load load_val and begin counting.
- load_val  input  WIDTH  start/reload value, sampled on start.
- auto_reload  input  1  sampled on start; 1 = periodic mode.
- pause  input  1  freeze count while counting.
- resume  input  1  continue from pause.
- abort  input  1  return to IDLE, clear count.
- count  output  WIDTH  current counter value.
- tc  output  1  one-cycle terminal-count pulse.
- busy  output  1  high in COUNT or PAUSE.
- done  output  1  high in DONE (one-shot finished).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, tc=0, busy=0, done=0, reload register=0, reload-mode flag=0. Takes effect immediately, including mid-count.
- All outputs are registered.
- Command priority, evaluated each rising edge: abort > start > pause > resume.
- States: IDLE, COUNT, PAUSE, DONE.
- IDLE: start with load_val≠0 → COUNT, count=load_val on the same edge; load_val and auto_reload are latched.
- start with load_val=0 (from any state): → DONE, count=0, tc=1 for one cycle.
- COUNT, decrement: each enabled cycle, count=count-1.
- COUNT, terminal count: on the edge where count goes 1→0, tc=1 on that same edge, so tc and count=0 appear together.
- COUNT, next edge after count=0:
  - auto_reload=1: count=latched value, stay in COUNT. Period is N+1 cycles, tc pulses once per period.
  - auto_reload=0: → DONE, count holds 0.
- COUNT, pause → PAUSE; count holds.
- COUNT, start → restart with the new load_val (re-latched).
- PAUSE: count holds; resume → COUNT, decrementing on the next enabled edge; start → restart; pause and resume both high → stay in PAUSE.
- DONE: done=1, busy=0. start → COUNT and done clears. resume and pause are ignored.
- abort in any state: → IDLE on the next edge, count=0, done=0, busy=0, tc=0.
- Cycle example, one-shot, load_val=3, start at edge E0:
  - count=3 after E0.
  - count=2 after E1, count=1 after E2.
  - count=0 and tc=1 after E3.
  - DONE and done=1 after E4.
- Count never wraps below 0. Decrement is blocked when count=0.
- resume outside PAUSE has no effect; pause outside COUNT has no effect.

Optional Feature:
- Macro: DOWN_COUNTER_CTRL_PRESCALE_EN.
- Defined: a prescaler counting 0..PRESCALE-1 gates decrements.
  - The counter decrements only on the cycle the prescaler wraps.
  - Prescaler clears on start, abort and reload; holds during PAUSE.
  - In auto_reload mode the count=0 phase also lasts PRESCALE cycles.
  - tc remains a single clk-cycle pulse.
- Not defined: decrement every cycle, no prescaler logic.

Decomposition:
- Package down_counter_pkg:
  - state enum (IDLE, COUNT, PAUSE, DONE, 2-bit encoding);
  - default WIDTH and PRESCALE constants.
- Sub-module down_counter_core (the datapath):
  - ports: clk, reset (asynchronous, active-low), load, load_val, dec_en, clr, count.
  - Priority clr > load > dec.
  - Saturates at 0.
- Controller FSM, latch registers and prescaler live in down_counter_ctrl.

Test Plan:
1. Reset mid-count: load_val=9, start, drop reset after 3 cycles → count=0, busy=0 immediately; restart after release → counts from 9.
2. One-shot: load_val=5, auto_reload=0, start → count 5,4,3,2,1,0; tc high exactly with count=0; done=1 one cycle later; busy falls.
3. Auto-reload: load_val=2, auto_reload=1 → sequence 2,1,0,2,1,0; tc every 3 cycles; done never asserts.
4. Pause/resume: load_val=6, pause when count=4 for 5 cycles → count stays 4; resume → continues 3,2,… with no lost or extra decrement.
5. Priority and edges:
   - abort+start in the same cycle → IDLE, count=0.
   - start with load_val=0 → DONE, tc=1 for one cycle.
   - start during COUNT at count=3 with load_val=7 → count=7.
6. With DOWN_COUNTER_CTRL_PRESCALE_EN and PRESCALE=4: load_val=2 → each value held 4 cycles; tc is a 1-cycle pulse; pausing mid-prescale preserves the prescaler phase.
